// File: rtl/dmi_unlock_gate.sv
// dmi_unlock_gate
//   Password gate between dmi_jtag (upstream) and dm_top (downstream).
//   DMI traffic is forwarded only after the correct 32-bit key has been written
//   to UNLOCK_ADDR. Wrong keys are counted; MAX_FAILS of them lock the gate out
//   until reset. Blocked requests are answered locally with an error response.
//
//   Optional feature macro: DMI_GATE_TIMEOUT_EN
//     defined   : watchdog in FWD/WAIT; after TIMEOUT_CYCLES the transaction is
//                 abandoned and answered locally with resp=2.
//     undefined : FWD/WAIT wait indefinitely.
//
// Ports
//   clk_i, rst_ni                     clock, async active-low reset
//   jtag_key_i        [31:0]          expected key (static after reset)
//   dmi_req_i         [40:0]          upstream request {addr[6:0], op[1:0], data[31:0]}
//   dmi_req_valid_i / dmi_req_ready_o upstream request handshake
//   dmi_resp_o        [33:0]          upstream response {data[31:0], resp[1:0]}
//   dmi_resp_valid_o / dmi_resp_ready_i
//   dmi_req_o         [40:0]          downstream request
//   dmi_req_valid_o / dmi_req_ready_i
//   dmi_resp_i        [33:0]          downstream response
//   dmi_resp_valid_i / dmi_resp_ready_o
//   unlocked_o, lockout_o             lock state flags
//
// Lock FSM
//   state       | meaning
//   LK_LOCKED   | waiting for key, wrong keys counted
//   LK_UNLOCKED | traffic forwarded; writing 0 to UNLOCK_ADDR relocks
//   LK_LOCKOUT  | too many wrong keys; absorbing until reset
//
// Transaction FSM
//   state    | meaning
//   TX_IDLE  | ready for a new upstream request
//   TX_FWD   | presenting registered request downstream
//   TX_WAIT  | waiting for downstream response
//   TX_LRESP | presenting registered response upstream

module dmi_unlock_gate #(
    parameter logic [6:0]  UNLOCK_ADDR    = 7'h7F,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] jtag_key_i,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic        unlocked_o,
    output logic        lockout_o
);

    localparam int unsigned FCW = $clog2(MAX_FAILS + 1);
    localparam logic [FCW-1:0] FAIL_MAX = FCW'(MAX_FAILS);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic [1:0] {LK_LOCKED, LK_UNLOCKED, LK_LOCKOUT} lock_e;
    typedef enum logic [1:0] {TX_IDLE, TX_FWD, TX_WAIT, TX_LRESP} txn_e;

    lock_e          lock_q, lock_d;
    txn_e           txn_q, txn_d;
    logic [FCW-1:0] fail_q, fail_d;
    logic [40:0]    req_q, req_d;
    logic [33:0]    resp_q, resp_d;
    logic           req_ready_q, req_ready_d;
    logic           req_valid_q, req_valid_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_ready_q, resp_ready_d;

    logic [6:0]  in_addr;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic        accept;
    logic        is_unlock;
    logic        key_wr;

    assign in_addr   = dmi_req_i[40:34];
    assign in_op     = dmi_req_i[33:32];
    assign in_data   = dmi_req_i[31:0];
    assign accept    = dmi_req_valid_i & req_ready_q;
    assign is_unlock = (in_addr == UNLOCK_ADDR);
    assign key_wr    = accept & is_unlock & (in_op == OP_WRITE);

`ifdef DMI_GATE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    assign tmo_hit = (tmo_q == '0);
`else
    logic [31:0] unused_tmo_cfg;
    assign unused_tmo_cfg = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= LK_LOCKED;
            txn_q        <= TX_IDLE;
            fail_q       <= '0;
            req_q        <= '0;
            resp_q       <= '0;
            req_ready_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_ready_q <= 1'b0;
`ifdef DMI_GATE_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            lock_q       <= lock_d;
            txn_q        <= txn_d;
            fail_q       <= fail_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
            req_ready_q  <= req_ready_d;
            req_valid_q  <= req_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_ready_q <= resp_ready_d;
`ifdef DMI_GATE_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    always_comb begin
        lock_d = lock_q;
        fail_d = fail_q;
        if (key_wr) begin
            case (lock_q)
                LK_LOCKED: begin
                    if (in_data == jtag_key_i) begin
                        lock_d = LK_UNLOCKED;
                        fail_d = '0;
                    end else begin
                        if (fail_q != FAIL_MAX) begin
                            fail_d = fail_q + 1'b1;
                        end
                        if (fail_q == FAIL_MAX - 1'b1) begin
                            lock_d = LK_LOCKOUT;
                        end
                    end
                end
                LK_UNLOCKED: begin
                    if (in_data == 32'h0) begin
                        lock_d = LK_LOCKED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        txn_d  = txn_q;
        req_d  = req_q;
        resp_d = resp_q;
`ifdef DMI_GATE_TIMEOUT_EN
        tmo_d  = (tmo_q != '0) ? tmo_q - 1'b1 : tmo_q;
`endif
        case (txn_q)
            TX_IDLE: begin
                if (accept) begin
                    if (is_unlock) begin
                        txn_d = TX_LRESP;
                        if (in_op == OP_READ) begin
                            resp_d = {30'b0, lock_q == LK_LOCKOUT, lock_q == LK_UNLOCKED, 2'b00};
                        end else begin
                            resp_d = '0;
                        end
                    end else if (lock_q == LK_UNLOCKED) begin
                        txn_d = TX_FWD;
                        req_d = dmi_req_i;
`ifdef DMI_GATE_TIMEOUT_EN
                        tmo_d = TW'(TIMEOUT_CYCLES);
`endif
                    end else begin
                        txn_d  = TX_LRESP;
                        resp_d = (in_op == OP_NOP) ? 34'h0 : {32'h0, RESP_ERR};
                    end
                end
            end
            TX_FWD: begin
                if (dmi_req_ready_i) begin
                    txn_d = TX_WAIT;
`ifdef DMI_GATE_TIMEOUT_EN
                end else if (tmo_hit) begin
                    txn_d  = TX_LRESP;
                    resp_d = {32'h0, RESP_ERR};
`endif
                end
            end
            TX_WAIT: begin
                if (dmi_resp_valid_i) begin
                    txn_d  = TX_LRESP;
                    resp_d = dmi_resp_i;
`ifdef DMI_GATE_TIMEOUT_EN
                end else if (tmo_hit) begin
                    txn_d  = TX_LRESP;
                    resp_d = {32'h0, RESP_ERR};
`endif
                end
            end
            TX_LRESP: begin
                if (dmi_resp_ready_i) begin
                    txn_d = TX_IDLE;
                end
            end
            default: txn_d = TX_IDLE;
        endcase

        // Handshake outputs are registered copies of the next state so that
        // none of them depends combinationally on an incoming valid or ready.
        req_ready_d  = (txn_d == TX_IDLE);
        req_valid_d  = (txn_d == TX_FWD);
        resp_ready_d = (txn_d == TX_WAIT);
        resp_valid_d = (txn_d == TX_LRESP);
    end

    assign dmi_req_ready_o  = req_ready_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_resp_valid_o = resp_valid_q;
    assign dmi_resp_o       = resp_q;
    assign unlocked_o       = (lock_q == LK_UNLOCKED);
    assign lockout_o        = (lock_q == LK_LOCKOUT);

endmodule
